// File: rtl/avaliador_ativos_pipe.sv
// rtl/avaliador_ativos_pipe.sv - active-node pool with a registered min-criterion comparator tree
// Defining AVALIADOR_APROVADO_EN adds aa_aprovado_out, the mask of every slot tied at the minimum.
module avaliador_ativos_pipe #(
   parameter int NUM_NA          = 8,
   parameter int ADDR_WIDTH      = 5,
   parameter int DISTANCIA_WIDTH = 5,
   parameter int CUSTO_WIDTH     = 4,
   parameter int CRITERIO_WIDTH  = DISTANCIA_WIDTH + 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cmd_valid_in,
   output logic                       cmd_ready_out,
   input  logic [1:0]                 cmd_op_in,
   input  logic [ADDR_WIDTH-1:0]      endereco_in,
   input  logic [DISTANCIA_WIDTH-1:0] distancia_in,
   input  logic [CUSTO_WIDTH-1:0]     custo_in,
   input  logic [ADDR_WIDTH-1:0]      anterior_in,
   output logic                       aa_pronto_out,
   output logic                       aa_tem_ativo_out,
   output logic                       aa_cheio_out,
   output logic                       aa_estouro_out,
   output logic [ADDR_WIDTH-1:0]      aa_melhor_endereco_out,
   output logic [DISTANCIA_WIDTH-1:0] aa_melhor_distancia_out,
   output logic [CRITERIO_WIDTH-1:0]  aa_melhor_criterio_out,
   output logic                       aa_anterior_we_out,
   output logic [ADDR_WIDTH-1:0]      aa_anterior_addr_out,
   output logic [ADDR_WIDTH-1:0]      aa_anterior_data_out
`ifdef AVALIADOR_APROVADO_EN
   ,
   output logic [NUM_NA-1:0]          aa_aprovado_out
`endif
);

   localparam int NIVEIS = $clog2(NUM_NA);
   localparam int CNTW   = $clog2(NIVEIS + 1);

   typedef enum logic [1:0] {OCIOSO, APLICA, CLASSIFICA, PRONTO} estado_t;

   estado_t                    r_estado;
   logic                       r_ready;
   logic                       r_pronto;
   logic [CNTW-1:0]            r_cnt;
   logic                       r_tem;
   logic                       r_cheio;
   logic                       r_estouro;
   logic                       r_we;
   logic [ADDR_WIDTH-1:0]      r_we_addr;
   logic [ADDR_WIDTH-1:0]      r_we_data;

   // The predecessor lives only in the external anterior memory, so slots do not keep it.
   logic [NUM_NA-1:0]          r_v;
   logic [ADDR_WIDTH-1:0]      r_addr [NUM_NA];
   logic [DISTANCIA_WIDTH-1:0] r_g    [NUM_NA];
   logic [CRITERIO_WIDTH-1:0]  r_crit [NUM_NA];

   logic                       r_c_wr;
   logic                       r_c_rm;
   logic                       r_c_fl;
   logic                       r_c_ov;
   logic [NIVEIS-1:0]          r_c_idx;
   logic [ADDR_WIDTH-1:0]      r_c_addr;
   logic [DISTANCIA_WIDTH-1:0] r_c_g;
   logic [CRITERIO_WIDTH-1:0]  r_c_crit;

   logic                       w_accept;
   logic                       w_hit;
   logic [NIVEIS-1:0]          w_hit_idx;
   logic                       w_free;
   logic [NIVEIS-1:0]          w_free_idx;
   logic                       w_melhora;
   logic                       w_ins;
   logic                       w_grava;
   logic [NIVEIS-1:0]          w_idx;
   logic [CRITERIO_WIDTH-1:0]  w_crit;
   logic [NUM_NA-1:0]          w_v_next;

   // Slots are frozen while a command is being accepted, so the decision is made on the inputs.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_idx  = '0;
      w_free     = 1'b0;
      w_free_idx = '0;
      for (int i = NUM_NA - 1; i >= 0; i--) begin
         if (r_v[i] && (r_addr[i] == endereco_in)) begin
            w_hit     = 1'b1;
            w_hit_idx = NIVEIS'(i);
         end
         if (!r_v[i]) begin
            w_free     = 1'b1;
            w_free_idx = NIVEIS'(i);
         end
      end
   end

   assign w_accept  = cmd_valid_in && r_ready;
   assign w_crit    = CRITERIO_WIDTH'(distancia_in) + CRITERIO_WIDTH'(custo_in);
   assign w_melhora = w_hit && (distancia_in < r_g[w_hit_idx]);
   assign w_ins     = (cmd_op_in == 2'b00);
   assign w_grava   = w_ins && (w_hit ? w_melhora : w_free);
   assign w_idx     = w_hit ? w_hit_idx : w_free_idx;

   always_comb begin
      w_v_next = r_v;
      if (r_estado == APLICA) begin
         if (r_c_fl)
            w_v_next = '0;
         else if (r_c_rm)
            w_v_next[r_c_idx] = 1'b0;
         else if (r_c_wr)
            w_v_next[r_c_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_estado  <= OCIOSO;
         r_ready   <= 1'b1;
         r_pronto  <= 1'b0;
         r_cnt     <= '0;
         r_tem     <= 1'b0;
         r_cheio   <= 1'b0;
         r_estouro <= 1'b0;
         r_we      <= 1'b0;
         r_we_addr <= '0;
         r_we_data <= '0;
         r_v       <= '0;
         r_c_wr    <= 1'b0;
         r_c_rm    <= 1'b0;
         r_c_fl    <= 1'b0;
         r_c_ov    <= 1'b0;
         r_c_idx   <= '0;
         r_c_addr  <= '0;
         r_c_g     <= '0;
         r_c_crit  <= '0;
         for (int i = 0; i < NUM_NA; i++) begin
            r_addr[i] <= '0;
            r_g[i]    <= '0;
            r_crit[i] <= '0;
         end
      end else begin
         r_we      <= 1'b0;
         r_we_addr <= '0;
         r_we_data <= '0;
         r_v       <= w_v_next;
         r_tem     <= |w_v_next;
         r_cheio   <= &w_v_next;
         case (r_estado)
            OCIOSO, PRONTO: begin
               if (w_accept) begin
                  r_estado <= APLICA;
                  r_ready  <= 1'b0;
                  r_pronto <= 1'b0;
                  r_c_wr   <= w_grava;
                  r_c_rm   <= (cmd_op_in == 2'b01) && w_hit;
                  r_c_fl   <= (cmd_op_in == 2'b10);
                  r_c_ov   <= w_ins && !w_hit && !w_free;
                  r_c_idx  <= w_idx;
                  r_c_addr <= endereco_in;
                  r_c_g    <= distancia_in;
                  r_c_crit <= w_crit;
                  if (w_grava) begin
                     r_we      <= 1'b1;
                     r_we_addr <= endereco_in;
                     r_we_data <= anterior_in;
                  end
               end
            end
            APLICA: begin
               if (r_c_wr && !r_c_fl) begin
                  r_addr[r_c_idx] <= r_c_addr;
                  r_g[r_c_idx]    <= r_c_g;
                  r_crit[r_c_idx] <= r_c_crit;
               end
               if (r_c_fl)
                  r_estouro <= 1'b0;
               else if (r_c_ov)
                  r_estouro <= 1'b1;
               r_cnt    <= CNTW'(NIVEIS - 1);
               r_estado <= CLASSIFICA;
            end
            CLASSIFICA: begin
               if (r_cnt == '0) begin
                  r_estado <= PRONTO;
                  r_ready  <= 1'b1;
                  r_pronto <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_estado <= OCIOSO;
         endcase
      end
   end

   // Heap-indexed tree: node n compares 2n and 2n+1, leaves sit at NUM_NA+slot.
   logic                       w_t_v [1:2*NUM_NA-1];
   logic [CRITERIO_WIDTH-1:0]  w_t_c [1:2*NUM_NA-1];
   logic [ADDR_WIDTH-1:0]      w_t_a [1:2*NUM_NA-1];
   logic [DISTANCIA_WIDTH-1:0] w_t_g [1:2*NUM_NA-1];
   logic                       r_t_v [1:NUM_NA-1];
   logic [CRITERIO_WIDTH-1:0]  r_t_c [1:NUM_NA-1];
   logic [ADDR_WIDTH-1:0]      r_t_a [1:NUM_NA-1];
   logic [DISTANCIA_WIDTH-1:0] r_t_g [1:NUM_NA-1];

   always_comb begin
      for (int n = 1; n < NUM_NA; n++) begin
         w_t_v[n] = r_t_v[n];
         w_t_c[n] = r_t_c[n];
         w_t_a[n] = r_t_a[n];
         w_t_g[n] = r_t_g[n];
      end
      for (int i = 0; i < NUM_NA; i++) begin
         w_t_v[NUM_NA+i] = r_v[i];
         w_t_c[NUM_NA+i] = r_v[i] ? r_crit[i] : '1;
         w_t_a[NUM_NA+i] = r_addr[i];
         w_t_g[NUM_NA+i] = r_g[i];
      end
   end

   // A valid criterion never reaches all-ones, so invalid leaves always lose; ties keep the left child.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 1; n < NUM_NA; n++) begin
            r_t_v[n] <= 1'b0;
            r_t_c[n] <= '0;
            r_t_a[n] <= '0;
            r_t_g[n] <= '0;
         end
      end else begin
         for (int n = 1; n < NUM_NA; n++) begin
            if (w_t_c[2*n+1] < w_t_c[2*n]) begin
               r_t_v[n] <= w_t_v[2*n+1];
               r_t_c[n] <= w_t_c[2*n+1];
               r_t_a[n] <= w_t_a[2*n+1];
               r_t_g[n] <= w_t_g[2*n+1];
            end else begin
               r_t_v[n] <= w_t_v[2*n];
               r_t_c[n] <= w_t_c[2*n];
               r_t_a[n] <= w_t_a[2*n];
               r_t_g[n] <= w_t_g[2*n];
            end
         end
      end
   end

   assign cmd_ready_out           = r_ready;
   assign aa_pronto_out           = r_pronto;
   assign aa_tem_ativo_out        = r_tem;
   assign aa_cheio_out            = r_cheio;
   assign aa_estouro_out          = r_estouro;
   assign aa_melhor_endereco_out  = r_t_v[1] ? r_t_a[1] : '0;
   assign aa_melhor_distancia_out = r_t_v[1] ? r_t_g[1] : '0;
   assign aa_melhor_criterio_out  = r_t_v[1] ? r_t_c[1] : '0;
   assign aa_anterior_we_out      = r_we;
   assign aa_anterior_addr_out    = r_we_addr;
   assign aa_anterior_data_out    = r_we_data;

`ifdef AVALIADOR_APROVADO_EN
   always_comb begin
      aa_aprovado_out = '0;
      for (int i = 0; i < NUM_NA; i++)
         aa_aprovado_out[i] = r_pronto && r_t_v[1] && r_v[i] && (r_crit[i] == r_t_c[1]);
   end
`endif

endmodule

// File: tb/tb_avaliador_ativos_pipe.sv
// tb/tb_avaliador_ativos_pipe.sv - scoreboard bench for the active-node pool (NUM_NA=4)
module tb_avaliador_ativos_pipe;

   localparam int N   = 4;
   localparam int AW  = 5;
   localparam int DW  = 5;
   localparam int CW  = 4;
   localparam int KW  = DW + 1;
   localparam int NIV = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid_in = 1'b0;
   logic          cmd_ready_out;
   logic [1:0]    cmd_op_in = 2'b11;
   logic [AW-1:0] endereco_in = '0;
   logic [DW-1:0] distancia_in = '0;
   logic [CW-1:0] custo_in = '0;
   logic [AW-1:0] anterior_in = '0;
   logic          aa_pronto_out, aa_tem_ativo_out, aa_cheio_out, aa_estouro_out;
   logic [AW-1:0] aa_melhor_endereco_out;
   logic [DW-1:0] aa_melhor_distancia_out;
   logic [KW-1:0] aa_melhor_criterio_out;
   logic          aa_anterior_we_out;
   logic [AW-1:0] aa_anterior_addr_out, aa_anterior_data_out;
`ifdef AVALIADOR_APROVADO_EN
   logic [N-1:0]  aa_aprovado_out;
`endif

   avaliador_ativos_pipe #(
      .NUM_NA(N), .ADDR_WIDTH(AW), .DISTANCIA_WIDTH(DW), .CUSTO_WIDTH(CW), .CRITERIO_WIDTH(KW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out), .cmd_op_in(cmd_op_in),
      .endereco_in(endereco_in), .distancia_in(distancia_in), .custo_in(custo_in),
      .anterior_in(anterior_in),
      .aa_pronto_out(aa_pronto_out), .aa_tem_ativo_out(aa_tem_ativo_out),
      .aa_cheio_out(aa_cheio_out), .aa_estouro_out(aa_estouro_out),
      .aa_melhor_endereco_out(aa_melhor_endereco_out),
      .aa_melhor_distancia_out(aa_melhor_distancia_out),
      .aa_melhor_criterio_out(aa_melhor_criterio_out),
      .aa_anterior_we_out(aa_anterior_we_out),
      .aa_anterior_addr_out(aa_anterior_addr_out),
      .aa_anterior_data_out(aa_anterior_data_out)
`ifdef AVALIADOR_APROVADO_EN
      , .aa_aprovado_out(aa_aprovado_out)
`endif
   );

   initial forever #5 clk = ~clk;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] wa;
      logic [AW-1:0] wd;
      logic          tem;
      logic          cheio;
      logic          est;
      logic [AW-1:0] ba;
      logic [DW-1:0] bg;
      logic [KW-1:0] bc;
      logic [N-1:0]  apr;
   } exp_t;

   exp_t          sb[$];
   int            n_tests = 0;
   int            n_fail = 0;

   logic          m_v [N];
   logic [AW-1:0] m_a [N];
   logic [DW-1:0] m_g [N];
   logic [KW-1:0] m_c [N];
   logic          m_est;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) m_v[i] = 1'b0;
      m_est = 1'b0;
   endtask

   task automatic model_apply(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] g,
                              input logic [CW-1:0] h, input logic [AW-1:0] p, output exp_t e);
      int hit = -1;
      int fr  = -1;
      int b   = -1;
      e = '0;
      for (int i = 0; i < N; i++) begin
         if (m_v[i] && m_a[i] == a && hit < 0) hit = i;
         if (!m_v[i] && fr < 0) fr = i;
      end
      case (op)
         2'b00: begin
            if (hit >= 0) begin
               if (g < m_g[hit]) begin
                  m_g[hit] = g;
                  m_c[hit] = KW'(g) + KW'(h);
                  e.we = 1'b1; e.wa = a; e.wd = p;
               end
            end else if (fr >= 0) begin
               m_v[fr] = 1'b1; m_a[fr] = a; m_g[fr] = g; m_c[fr] = KW'(g) + KW'(h);
               e.we = 1'b1; e.wa = a; e.wd = p;
            end else begin
               m_est = 1'b1;
            end
         end
         2'b01: if (hit >= 0) m_v[hit] = 1'b0;
         2'b10: model_clear();
         default: ;
      endcase
      for (int i = 0; i < N; i++)
         if (m_v[i] && (b < 0 || m_c[i] < m_c[b])) b = i;
      e.est = m_est;
      e.cheio = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (m_v[i]) e.tem = 1'b1;
         else e.cheio = 1'b0;
      end
      if (b >= 0) begin
         e.ba = m_a[b]; e.bg = m_g[b]; e.bc = m_c[b];
         for (int i = 0; i < N; i++)
            if (m_v[i] && m_c[i] == m_c[b]) e.apr[i] = 1'b1;
      end
   endtask

   // Called at a negedge; returns at the negedge where pronto is observed.
   task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] g,
                       input logic [CW-1:0] h, input logic [AW-1:0] p);
      exp_t e;
      int   n = 0;
      while (!cmd_ready_out && n < 64) begin @(negedge clk); n++; end
      chk("ready", 32'(cmd_ready_out), 1);
      if (!cmd_ready_out) return;
      cmd_valid_in = 1'b1; cmd_op_in = op; endereco_in = a;
      distancia_in = g; custo_in = h; anterior_in = p;
      model_apply(op, a, g, h, p, e);
      sb.push_back(e);
      @(negedge clk);
      cmd_valid_in = 1'b0;
      chk("we_t1", 32'(aa_anterior_we_out), 32'(sb[0].we));
      chk("we_addr", 32'(aa_anterior_addr_out), 32'(sb[0].wa));
      chk("we_data", 32'(aa_anterior_data_out), 32'(sb[0].wd));
      chk("ready_busy", 32'(cmd_ready_out), 0);
      n = 1;
      while (!aa_pronto_out && n < 64) begin
         @(negedge clk); n++;
         if (n == 2) chk("we_pulse_end", 32'(aa_anterior_we_out), 0);
      end
      chk("latency", 32'(n), 32'(NIV + 2));
      e = sb.pop_front();
      chk("tem_ativo", 32'(aa_tem_ativo_out), 32'(e.tem));
      chk("cheio", 32'(aa_cheio_out), 32'(e.cheio));
      chk("estouro", 32'(aa_estouro_out), 32'(e.est));
      chk("best_addr", 32'(aa_melhor_endereco_out), 32'(e.ba));
      chk("best_g", 32'(aa_melhor_distancia_out), 32'(e.bg));
      chk("best_crit", 32'(aa_melhor_criterio_out), 32'(e.bc));
`ifdef AVALIADOR_APROVADO_EN
      chk("aprovado", 32'(aa_aprovado_out), 32'(e.apr));
`endif
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_pronto"}, 32'(aa_pronto_out), 0);
      chk({tag, "_tem"}, 32'(aa_tem_ativo_out), 0);
      chk({tag, "_cheio"}, 32'(aa_cheio_out), 0);
      chk({tag, "_estouro"}, 32'(aa_estouro_out), 0);
      chk({tag, "_we"}, 32'(aa_anterior_we_out), 0);
      chk({tag, "_best"}, {aa_melhor_endereco_out, aa_melhor_distancia_out, aa_melhor_criterio_out}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      repeat (3) @(negedge clk);
      check_idle_zero("reset");
      chk("reset_ready", 32'(cmd_ready_out), 1);
      rst_n = 1'b1;
      @(negedge clk);

      send(2'b00, 5'd3, 5'd4, 4'd2, 5'd9);
      send(2'b00, 5'd7, 5'd2, 4'd1, 5'd1);
      send(2'b00, 5'd3, 5'd5, 4'd2, 5'd2);
      send(2'b01, 5'd7, 5'd0, 4'd0, 5'd0);
      send(2'b01, 5'd20, 5'd0, 4'd0, 5'd0);
      send(2'b00, 5'd3, 5'd1, 4'd2, 5'd4);
      send(2'b11, 5'd3, 5'd0, 4'd0, 5'd0);

      send(2'b00, 5'd10, 5'd31, 4'd15, 5'd5);
      send(2'b00, 5'd11, 5'd8, 4'd3, 5'd6);
      send(2'b00, 5'd12, 5'd0, 4'd0, 5'd7);
      send(2'b00, 5'd13, 5'd1, 4'd1, 5'd8);
      send(2'b10, 5'd0, 5'd0, 4'd0, 5'd0);

      send(2'b00, 5'd1, 5'd9, 4'd0, 5'd1);
      send(2'b00, 5'd2, 5'd3, 4'd2, 5'd1);
      send(2'b00, 5'd4, 5'd5, 4'd0, 5'd1);
      send(2'b10, 5'd0, 5'd0, 4'd0, 5'd0);

      send(2'b00, 5'd5, 5'd6, 4'd6, 5'd2);
      send(2'b01, 5'd5, 5'd0, 4'd0, 5'd0);

      for (int k = 0; k < 48; k++) begin
         int r;
         logic [1:0] op;
         r = $urandom_range(0, 9);
         op = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         send(op, AW'($urandom_range(0, 7)), DW'($urandom_range(0, 31)),
              CW'($urandom_range(0, 15)), AW'($urandom_range(0, 31)));
      end

      for (int k = 0; k < 5; k++)
         send(2'b00, AW'(16 + k), DW'(k + 1), 4'd1, 5'd3);

      cmd_valid_in = 1'b1; cmd_op_in = 2'b00; endereco_in = 5'd30;
      distancia_in = 5'd1; custo_in = 4'd1; anterior_in = 5'd3;
      @(negedge clk);
      cmd_valid_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle_zero("midreset");
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("postreset_ready", 32'(cmd_ready_out), 1);
      check_idle_zero("postreset");
      send(2'b00, 5'd9, 5'd2, 4'd2, 5'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
